rca_seq_addsub: RTL and testbench
=================================

Name: rca_seq_addsub

Overview:
- Parametrised, multi-cycle, digit-serial add/subtract unit; next generation of the team's fixed 36-bit ripple-carry adder.
- Reuses one CHUNK-bit ripple-carry slice over WIDTH/CHUNK cycles, with a registered carry between chunks.
- Adds subtract mode, signed-overflow detection and valid/ready handshakes on input and output.
- Sits in datapaths where adder area matters more than latency.

Parameters:
- WIDTH, 36, operand and sum width in bits.
- CHUNK, 4, bits processed per cycle. WIDTH mod CHUNK must be 0; any other value is an elaboration error. NCHUNK = WIDTH/CHUNK.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  unit can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in. Used only when sub=0.
- sub  input  1  0: S=A+B+cin. 1: S=A-B, computed as A+~B+1.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- s  output  WIDTH  sum or difference.
- cout  output  1  carry out of bit WIDTH-1. When sub=1, cout=1 means no borrow.
- ovf  output  1  two's-complement overflow: carry into the MSB XOR carry out of the MSB.

Behaviour:
- Reset (async, while rst=1): state=IDLE, in_ready=1, out_valid=0, s=0, cout=0, ovf=0, chunk index=0, carry register=0. Any operation in progress is discarded.
- States are IDLE, RUN and DONE.
  - IDLE: in_ready=1. On in_valid&in_ready at an edge:
    - capture a;
    - capture b, or ~b if sub=1;
    - carry register gets cin if sub=0, 1 if sub=1;
    - index=0; state becomes RUN.
  - RUN: in_ready=0, out_valid=0. Each edge:
    - chunk k=index: s[k*CHUNK +: CHUNK] gets the low CHUNK bits of A_k + B'_k + carry;
    - carry register gets the carry out of the chunk;
    - index increments.
    - On the edge processing k=NCHUNK-1: cout gets the chunk carry out, ovf gets (carry into bit WIDTH-1) XOR cout, state becomes DONE.
  - DONE: out_valid=1, in_ready=0. s, cout and ovf are held stable while out_ready=0. On out_valid&out_ready at an edge, state becomes IDLE.
- Latency: out_valid rises NCHUNK cycles after the accepting edge. With the default parameters this is 9 cycles.
- Throughput: at most one operation per NCHUNK+2 cycles. There is no bypass from DONE to a new accept; in_ready goes high only in the cycle after the result handshake.
- Input values are sampled only at the accepting edge. Changes to a, b, sub or cin during RUN or DONE have no effect.
- in_valid while in_ready=0 is ignored. The producer holds its operands until it sees a handshake.
- s and cout keep their last values in IDLE. out_valid is the only qualifier for the result.
- Partially built s bits are visible during RUN and are not valid data.
- NCHUNK=1 is legal: a single RUN cycle, then DONE.
- Arithmetic wraps modulo 2^WIDTH.
- Reset asserted during RUN or DONE aborts immediately. The next operation after reset release starts clean.

Test Plan:
- Reset, then add a=0x0_0000_0005, b=0x0_0000_0003, cin=1, sub=0. Expect s=0x0_0000_0009, cout=0, ovf=0, with out_valid exactly 9 cycles after the accepting edge.
- Carry ripple across every chunk: add a=0xF_FFFF_FFFF, b=0x0_0000_0001, cin=0. Expect s=0, cout=1, ovf=0.
- Subtract 5-7: a=0x0_0000_0005, b=0x0_0000_0007, sub=1, cin=1. cin must be ignored. Expect s=0xF_FFFF_FFFE, cout=0, ovf=0.
- Signed overflow: add a=0x7_FFFF_FFFF and b=0x0_0000_0001. Expect s=0x8_0000_0000, ovf=1, cout=0.
- Backpressure:
  - Hold out_ready=0 for 5 cycles after out_valid; s, cout, ovf and out_valid must stay stable and in_ready must stay 0.
  - Then pulse out_ready; in_ready=1 on the next cycle.
  - Back-to-back operations are spaced at least 11 cycles apart.
- Reset mid-RUN: assert rst at chunk 4 of an operation. Outputs go to their reset values asynchronously. A following a=1, b=1 operation yields s=2.
- Parameter sweep (WIDTH,CHUNK) = (36,36), (36,12), (8,1). Run 1000 random a, b, cin, sub each and compare to a reference model, including cout and ovf; latency must equal WIDTH/CHUNK.

Source files
------------

// File: rtl/rca_seq_addsub.sv
// Digit-serial add/subtract unit. One CHUNK-bit ripple slice is reused over
// WIDTH/CHUNK cycles with a registered carry between chunks. Operands are
// captured on the input handshake and the result is held until the output
// handshake.
module rca_seq_addsub #(
    parameter int WIDTH = 36,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(NCHUNK - 1);

    // Operand width must split into whole chunks.
    generate
        if (WIDTH % CHUNK != 0) begin : g_bad_chunk
            $error("rca_seq_addsub: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;      // already inverted for subtract
    logic [WIDTH-1:0]  s_q, s_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              carry_q, carry_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;

    logic [CHUNK-1:0]  a_k, b_k;
    logic [CHUNK:0]    sum_k;
    logic              c_msb;          // carry into the top bit of the chunk

    // Shared ripple slice for the current chunk.
    assign a_k   = a_q[idx_q*CHUNK +: CHUNK];
    assign b_k   = b_q[idx_q*CHUNK +: CHUNK];
    assign sum_k = {1'b0, a_k} + {1'b0, b_k} + {{CHUNK{1'b0}}, carry_q};
    assign c_msb = sum_k[CHUNK-1] ^ a_k[CHUNK-1] ^ b_k[CHUNK-1];

    // Next-state logic: accept in IDLE, one chunk per cycle in RUN, hold in DONE.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        s_d      = s_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                s_d[idx_q*CHUNK +: CHUNK] = sum_k[CHUNK-1:0];
                carry_d = sum_k[CHUNK];
                idx_d   = idx_q + IDXW'(1);
                if (idx_q == LAST) begin
                    cout_d  = sum_k[CHUNK];
                    ovf_d   = c_msb ^ sum_k[CHUNK];
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // State and output registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            s_q         <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            s_q         <= s_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign s         = s_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_rca_seq_addsub.sv
// Bench for rca_seq_addsub: directed cases and random traffic on the default
// 36/4 instance, plus random sweeps on 36/36, 36/12 and 8/1 instances. Drivers
// push expected results into per-instance queues; monitors pop on out_valid.
module tb_rca_seq_addsub;

    typedef struct {
        logic [63:0] s;
        logic        cout;
        logic        ovf;
        int          acc;   // cycle number of the accepting edge
    } exp_t;

    localparam int W  = 36;
    localparam int NC = 9;

    logic          clk = 1'b0;
    logic          rst, rst_sw;
    logic          in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
    logic [W-1:0]  a, b, s;
    logic          rdy_rand, rdy_force;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int sw_done = 0;
    int last_acc = -1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rca_seq_addsub #(.WIDTH(W), .CHUNK(4)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .cout(cout), .ovf(ovf)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // Reference: plain unsigned arithmetic for s/cout, signed range test for ovf.
    function automatic exp_t ref_model(input int w, input logic [63:0] ai, input logic [63:0] bi,
                                       input logic ci, input logic si);
        exp_t e;
        logic [63:0] m, tot;
        longint sa, sb, r, hi, lo;
        m  = (64'd1 << w) - 64'd1;
        ai = ai & m;
        bi = bi & m;
        if (si) begin
            e.s    = (ai - bi) & m;
            e.cout = (ai >= bi);
        end else begin
            tot    = ai + bi + 64'(ci);
            e.s    = tot & m;
            e.cout = (tot > m);
        end
        sa = longint'(ai);
        if (ai[w-1]) sa = sa - (longint'(1) << w);
        sb = longint'(bi);
        if (bi[w-1]) sb = sb - (longint'(1) << w);
        r  = si ? (sa - sb) : (sa + sb + longint'(ci));
        hi = (longint'(1) << (w-1)) - 1;
        lo = -(longint'(1) << (w-1));
        e.ovf = (r > hi) || (r < lo);
        e.acc = 0;
        return e;
    endfunction

    function automatic logic [63:0] pick(input int w);
        logic [63:0] m;
        m = (64'd1 << w) - 64'd1;
        case ($urandom_range(0, 7))
            0:       return m;
            1:       return 64'd0;
            2:       return 64'd1 << (w-1);
            3:       return m >> 1;
            default: return {$urandom, $urandom} & m;
        endcase
    endfunction

    // out_ready for the main instance changes only just after a rising edge.
    always @(posedge clk) begin
        #1;
        out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
    end

    // Main monitor: check first result cycle, then hold stability until handshake.
    exp_t q0[$];
    exp_t cur0;
    logic seen0 = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            seen0 = 1'b0;
        end else if (out_valid) begin
            if (!seen0) begin
                if (q0.size() == 0) begin
                    chk("main_unexpected_result", 64'(out_valid), 64'd0);
                end else begin
                    cur0 = q0.pop_front();
                    chk("main_latency", 64'(cyc - cur0.acc), 64'(NC));
                    chk("main_s",    64'(s),    cur0.s);
                    chk("main_cout", 64'(cout), 64'(cur0.cout));
                    chk("main_ovf",  64'(ovf),  64'(cur0.ovf));
                end
                seen0 = 1'b1;
            end else begin
                chk("main_hold_s",    64'(s),    cur0.s);
                chk("main_hold_cout", 64'(cout), 64'(cur0.cout));
                chk("main_hold_ovf",  64'(ovf),  64'(cur0.ovf));
            end
            if (out_ready) seen0 = 1'b0;
        end
    end

    // Present operands until accepted, then scramble them to show they are unused.
    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic, input logic is);
        int t;
        exp_t e;
        @(posedge clk); #1;
        a = ia; b = ib; cin = ic; sub = is; in_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 200) begin @(negedge clk); t++; end
        chk("main_accept", 64'(in_ready), 64'd1);
        if (in_ready) begin
            e = ref_model(W, 64'(ia), 64'(ib), ic, is);
            e.acc = cyc + 1;
            q0.push_back(e);
            if (last_acc >= 0) chk("main_spacing", 64'(e.acc - last_acc >= NC + 2), 64'd1);
            last_acc = e.acc;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = W'({$urandom, $urandom}); b = W'({$urandom, $urandom});
        cin = 1'($urandom); sub = 1'($urandom);
    endtask

    task automatic drain;
        int t;
        t = 0;
        while ((q0.size() != 0 || !in_ready) && t < 300) begin @(negedge clk); t++; end
        chk("main_drain", 64'(q0.size() == 0 && in_ready), 64'd1);
    endtask

    // Parameter sweep instances, each with its own driver, queue and monitor.
    for (genvar g = 0; g < 3; g++) begin : g_sw
        localparam int GW = (g == 2) ? 8 : 36;
        localparam int GC = (g == 0) ? 36 : ((g == 1) ? 12 : 1);
        localparam int GN = GW / GC;
        logic          iv, ir, ci, sb, ov, orr, co, of;
        logic [GW-1:0] ga, gb, gs;
        exp_t          q[$];
        exp_t          cur;
        logic          seen = 1'b0;

        rca_seq_addsub #(.WIDTH(GW), .CHUNK(GC)) u_sw (
            .clk(clk), .rst(rst_sw), .in_valid(iv), .in_ready(ir),
            .a(ga), .b(gb), .cin(ci), .sub(sb),
            .out_valid(ov), .out_ready(orr),
            .s(gs), .cout(co), .ovf(of)
        );

        always @(posedge clk) begin
            #1;
            orr = ($urandom_range(0, 3) != 0);
        end

        initial begin
            logic [63:0] ra, rb;
            int t;
            exp_t e;
            iv = 1'b0; ga = '0; gb = '0; ci = 1'b0; sb = 1'b0;
            @(negedge clk);
            while (rst_sw) @(negedge clk);
            for (int n = 0; n < 1000; n++) begin
                ra = pick(GW);
                rb = pick(GW);
                @(posedge clk); #1;
                ga = ra[GW-1:0]; gb = rb[GW-1:0];
                ci = 1'($urandom); sb = 1'($urandom); iv = 1'b1;
                t = 0;
                @(negedge clk);
                while (!ir && t < 100) begin @(negedge clk); t++; end
                chk($sformatf("sw%0d_accept", g), 64'(ir), 64'd1);
                if (ir) begin
                    e = ref_model(GW, ra, rb, ci, sb);
                    e.acc = cyc + 1;
                    q.push_back(e);
                end
                @(posedge clk); #1;
                iv = 1'b0;
                repeat ($urandom_range(0, 2)) @(posedge clk);
            end
            t = 0;
            while (q.size() != 0 && t < 200) begin @(negedge clk); t++; end
            chk($sformatf("sw%0d_drain", g), 64'(q.size()), 64'd0);
            sw_done++;
        end

        always @(negedge clk) begin
            if (rst_sw) begin
                seen = 1'b0;
            end else if (ov) begin
                if (!seen) begin
                    if (q.size() == 0) begin
                        chk($sformatf("sw%0d_unexpected_result", g), 64'(ov), 64'd0);
                    end else begin
                        cur = q.pop_front();
                        chk($sformatf("sw%0d_latency", g), 64'(cyc - cur.acc), 64'(GN));
                        chk($sformatf("sw%0d_s", g),    64'(gs), cur.s);
                        chk($sformatf("sw%0d_cout", g), 64'(co), 64'(cur.cout));
                        chk($sformatf("sw%0d_ovf", g),  64'(of), 64'(cur.ovf));
                    end
                    seen = 1'b1;
                end else begin
                    chk($sformatf("sw%0d_hold_s", g), 64'(gs), cur.s);
                end
                if (orr) seen = 1'b0;
            end
        end
    end

    initial begin
        int t;
        rst = 1'b0; rst_sw = 1'b0;
        in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        rdy_rand = 1'b0; rdy_force = 1'b1; out_ready = 1'b1;
        #1;
        rst = 1'b1; rst_sw = 1'b1;
        #3;
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_s",         64'(s),         64'd0);
        chk("rst_cout",      64'(cout),      64'd0);
        chk("rst_ovf",       64'(ovf),       64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0; rst_sw = 1'b0;

        // Directed arithmetic corners.
        issue(36'h0_0000_0005, 36'h0_0000_0003, 1'b1, 1'b0); drain();
        issue(36'hF_FFFF_FFFF, 36'h0_0000_0001, 1'b0, 1'b0); drain();
        issue(36'h0_0000_0005, 36'h0_0000_0007, 1'b1, 1'b1); drain();
        issue(36'h7_FFFF_FFFF, 36'h0_0000_0001, 1'b0, 1'b0); drain();

        // Backpressure: result held for 5 cycles, then one handshake.
        rdy_force = 1'b0;
        @(negedge clk);
        issue(36'h1_2345_6789, 36'h0_FEDC_BA98, 1'b0, 1'b0);
        t = 0;
        while (!out_valid && t < 50) begin @(negedge clk); t++; end
        chk("bp_out_valid_seen", 64'(out_valid), 64'd1);
        repeat (5) begin
            @(negedge clk);
            chk("bp_in_ready_low",   64'(in_ready),  64'd0);
            chk("bp_out_valid_high", 64'(out_valid), 64'd1);
        end
        rdy_force = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_in_ready_after", 64'(in_ready),  64'd1);
        chk("bp_out_valid_after", 64'(out_valid), 64'd0);

        // Back-to-back operations with out_ready held high.
        issue(36'h0_0000_00FF, 36'h0_0000_0001, 1'b0, 1'b0);
        issue(36'h8_0000_0000, 36'h0_0000_0001, 1'b0, 1'b1);
        drain();

        // Reset in the middle of RUN, at chunk 4.
        issue(36'h1_1111_1111, 36'h2_2222_2222, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_in_ready",  64'(in_ready),  64'd1);
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_s",         64'(s),         64'd0);
        chk("mid_rst_cout",      64'(cout),      64'd0);
        chk("mid_rst_ovf",       64'(ovf),       64'd0);
        q0.delete();
        last_acc = -1;
        @(negedge clk);
        rst = 1'b0;
        issue(36'h0_0000_0001, 36'h0_0000_0001, 1'b0, 1'b0); drain();

        // Random traffic with random output backpressure.
        rdy_rand = 1'b1;
        for (int n = 0; n < 200; n++) begin
            issue(W'(pick(W)), W'(pick(W)), 1'($urandom), 1'($urandom));
        end
        drain();

        t = 0;
        while (sw_done < 3 && t < 40000) begin @(negedge clk); t++; end
        chk("sweep_complete", 64'(sw_done), 64'd3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
